johnson_seq_ctrl: RTL and testbench

Command-driven sequencer for the 4-bit twisted-ring (Johnson) phase generator. Accepts a move command (direction, step count, step period) over a valid/ready handshake. Advances the phase pattern one position per period and pulses `done` when finished or aborted. Sits between the host control logic and any phase-driven load, such as a stepper driver or multiphase strobe.

---
 rtl/johnson_seq_pkg.sv | 24 ++
 rtl/johnson_seq_ctrl_ring.sv | 45 ++++
 rtl/johnson_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_johnson_seq_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/johnson_seq_pkg.sv
// Shared types and helpers for the Johnson phase sequencer.
// The JSEQ_SELFCORRECT_EN build uses phase_is_legal() for illegal-pattern recovery.
`timescale 1ns/1ps
package johnson_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } jseq_state_e;

    localparam logic [3:0] PHASE_RESET = 4'b0001;

    function automatic logic phase_is_legal(input logic [3:0] phase);
        logic legal;
        case (phase)
            4'b0001, 4'b0011, 4'b0111, 4'b1111,
            4'b1110, 4'b1100, 4'b1000, 4'b0000: legal = 1'b1;
            default:                             legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/johnson_seq_ctrl_ring.sv
// 4-bit twisted-ring phase register: steps forward/reverse when enabled,
// and load forces the reset pattern regardless of en.
`timescale 1ns/1ps
module johnson_ring
    import johnson_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       dir,
    input  logic       load,
    output logic [3:0] phase
);

    logic [3:0] phase_q;
    logic [3:0] phase_d;

    // Next phase: recovery load beats stepping; reverse is the exact inverse of forward
    always_comb begin
        phase_d = phase_q;
        if (load) begin
            phase_d = PHASE_RESET;
        end else if (en) begin
            if (dir) begin
                phase_d = {phase_q[2:0], ~phase_q[3]};
            end else begin
                phase_d = {~phase_q[0], phase_q[3:1]};
            end
        end else begin
            phase_d = phase_q;
        end
    end

    // Phase register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= PHASE_RESET;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Command-driven sequencer for the Johnson phase ring.
// Optional macro JSEQ_SELFCORRECT_EN adds illegal-phase recovery and the err pulse.
`timescale 1ns/1ps
module johnson_seq_ctrl
    import johnson_seq_pkg::*;
#(
    parameter int COUNT_W  = 8,
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [COUNT_W-1:0]  cmd_steps,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic                abort,
    output logic [3:0]          phase_out,
    output logic                busy,
    output logic                done,
    output logic [COUNT_W-1:0]  steps_left,
    output logic                err
);

    localparam logic [PERIOD_W-1:0] PERIOD_ZERO = {PERIOD_W{1'b0}};
    localparam logic [PERIOD_W-1:0] PERIOD_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0]  COUNT_ZERO  = {COUNT_W{1'b0}};
    localparam logic [COUNT_W-1:0]  COUNT_ONE   = {{(COUNT_W-1){1'b0}}, 1'b1};

    jseq_state_e         state_q, state_d;
    logic                dir_q, dir_d;
    logic [PERIOD_W-1:0] presc_q, presc_d;
    logic [PERIOD_W-1:0] reload_q, reload_d;
    logic [COUNT_W-1:0]  steps_q, steps_d;
    logic                cmd_ready_q;
    logic                busy_q;
    logic                done_q;
    logic                step_en_s;
    logic                illegal_s;
    logic [3:0]          phase_s;

    // Next-state logic for the FSM, prescaler and step counter
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        presc_d   = presc_q;
        reload_d  = reload_q;
        steps_d   = steps_q;
        step_en_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    dir_d    = cmd_dir;
                    steps_d  = cmd_steps;
                    reload_d = (cmd_period == PERIOD_ZERO) ? PERIOD_ZERO
                                                           : (cmd_period - PERIOD_ONE);
                    presc_d  = reload_d;
                    state_d  = (cmd_steps == COUNT_ZERO) ? DONE : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Abort wins over a step due on the same edge; steps_left keeps its value
                if (abort) begin
                    state_d = DONE;
                end else if (presc_q == PERIOD_ZERO) begin
                    step_en_s = 1'b1;
                    presc_d   = reload_q;
                    steps_d   = steps_q - COUNT_ONE;
                    state_d   = (steps_q == COUNT_ONE) ? DONE : RUN;
                end else begin
                    presc_d = presc_q - PERIOD_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered status outputs, decoded from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            dir_q       <= 1'b1;
            presc_q     <= PERIOD_ZERO;
            reload_q    <= PERIOD_ZERO;
            steps_q     <= COUNT_ZERO;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            presc_q     <= presc_d;
            reload_q    <= reload_d;
            steps_q     <= steps_d;
            cmd_ready_q <= (state_d == IDLE);
            busy_q      <= (state_d == RUN);
            done_q      <= (state_d == DONE);
        end
    end

`ifdef JSEQ_SELFCORRECT_EN
    logic err_q;

    assign illegal_s = !phase_is_legal(phase_s);

    // Flag the edge on which an illegal pattern was replaced by the reset pattern
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= illegal_s;
        end
    end

    assign err = err_q;
`else
    assign illegal_s = 1'b0;
    assign err       = 1'b0;
`endif

    johnson_ring u_ring (
        .clk   (clk),
        .reset (reset),
        .en    (step_en_s),
        .dir   (dir_q),
        .load  (illegal_s),
        .phase (phase_s)
    );

    assign phase_out  = phase_s;
    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign steps_left = steps_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Self-checking bench for johnson_seq_ctrl: directed cases plus randomized
// commands checked cycle by cycle against a position-in-sequence model.
`timescale 1ns/1ps
module tb_johnson_seq_ctrl;

    localparam int COUNT_W  = 8;
    localparam int PERIOD_W = 16;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic                cmd_dir = 1'b1;
    logic [COUNT_W-1:0]  cmd_steps = '0;
    logic [PERIOD_W-1:0] cmd_period = '0;
    logic                abort = 1'b0;
    logic [3:0]          phase_out;
    logic                busy;
    logic                done;
    logic [COUNT_W-1:0]  steps_left;
    logic                err;

    int n_checks = 0;
    int n_pass   = 0;
    int pos      = 0;

    logic [3:0] seq_tbl [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                4'b1110, 4'b1100, 4'b1000, 4'b0000};

    johnson_seq_ctrl #(.COUNT_W(COUNT_W), .PERIOD_W(PERIOD_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .abort      (abort),
        .phase_out  (phase_out),
        .busy       (busy),
        .done       (done),
        .steps_left (steps_left),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int model_pos(input int start, input bit dir, input int s);
        if (dir) return (start + s) % 8;
        return (((start - s) % 8) + 8) % 8;
    endfunction

    task automatic check_reset_values();
        check_val("rst_phase", 32'(phase_out), 32'h1);
        check_val("rst_ready", 32'(cmd_ready), 32'h1);
        check_val("rst_busy",  32'(busy),      32'h0);
        check_val("rst_done",  32'(done),      32'h0);
        check_val("rst_err",   32'(err),       32'h0);
        check_val("rst_left",  32'(steps_left), 32'h0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        check_reset_values();
        @(negedge clk);
        reset = 1'b1;
        pos = 0;
    endtask

    // One command: drive at a negedge, accept on E0, check after every edge up to ready again
    task automatic run_cmd(input bit dir, input int n, input int per, input int abort_at,
                           input bit hold_valid);
        int p, full, t_end, done_steps, s, w;
        p    = (per == 0) ? 1 : per;
        full = n * p;
        if (n == 0) begin
            t_end = 0; done_steps = 0;
        end else if (abort_at != 0 && abort_at <= full) begin
            t_end = abort_at; done_steps = (abort_at - 1) / p;
        end else begin
            t_end = full; done_steps = n;
        end
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_val("ready_before_cmd", 32'(cmd_ready), 32'h1);
        cmd_valid  = 1'b1;
        cmd_dir    = dir;
        cmd_steps  = COUNT_W'(n);
        cmd_period = PERIOD_W'(per);
        abort      = 1'b0;
        for (int t = 0; t <= t_end + 1; t++) begin
            @(negedge clk);
            s = (t / p < done_steps) ? t / p : done_steps;
            check_val("phase", 32'(phase_out), 32'(seq_tbl[model_pos(pos, dir, s)]));
            check_val("steps_left", 32'(steps_left), 32'((n - s) & 255));
            check_val("busy",  32'(busy),      32'(t < t_end));
            check_val("done",  32'(done),      32'(t == t_end));
            check_val("ready", 32'(cmd_ready), 32'(t > t_end));
            check_val("err",   32'(err),       32'h0);
            if (hold_valid && t < t_end) begin
                cmd_dir    = 1'($urandom);
                cmd_steps  = COUNT_W'($urandom);
                cmd_period = PERIOD_W'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            // Unplanned abort is raised only while DONE, where it must be ignored
            abort = (abort_at != 0 && t + 1 == abort_at) ||
                    (abort_at == 0 && hold_valid && t == t_end);
        end
        abort = 1'b0;
        pos = model_pos(pos, dir, done_steps);
    endtask

    initial begin
        int n, per, ab;
        reset = 1'b0;
        @(negedge clk);
        check_reset_values();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values();

        // Forward 3 steps, period 1
        run_cmd(1'b1, 3, 1, 0, 1'b0);
        check_val("fwd3_phase", 32'(phase_out), 32'h0000000f);
        check_val("fwd3_left",  32'(steps_left), 32'h0);

        // Reverse 2 steps, period 4, from 0001
        pulse_reset();
        run_cmd(1'b0, 2, 4, 0, 1'b0);
        check_val("rev2_phase", 32'(phase_out), 32'h00000008);

        // Zero steps leaves the phase alone
        run_cmd(1'b1, 0, 5, 0, 1'b0);
        check_val("zero_phase", 32'(phase_out), 32'h00000008);

        // Abort sampled at E4 of a period-2 command
        pulse_reset();
        run_cmd(1'b1, 10, 2, 4, 1'b0);
        check_val("abort_left",  32'(steps_left), 32'd9);
        check_val("abort_phase", 32'(phase_out), 32'h00000003);

        // Full wrap
        pulse_reset();
        run_cmd(1'b1, 8, 1, 0, 1'b0);
        check_val("wrap_phase", 32'(phase_out), 32'h00000001);

        // Illegal pattern injection
        @(negedge clk);
        force dut.u_ring.phase_q = 4'b0101;
        #1;
        release dut.u_ring.phase_q;
        @(negedge clk);
`ifdef JSEQ_SELFCORRECT_EN
        check_val("fix_phase", 32'(phase_out), 32'h00000001);
        check_val("fix_err",   32'(err),       32'h1);
        @(negedge clk);
        check_val("fix_err_end", 32'(err), 32'h0);
`else
        check_val("nofix_phase", 32'(phase_out), 32'h00000005);
        check_val("nofix_err",   32'(err),       32'h0);
        @(negedge clk);
        check_val("nofix_err2",  32'(err),       32'h0);
`endif
        pulse_reset();

        // Reset in the middle of a command
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 8'd20; cmd_period = 16'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_val("mid_busy", 32'(busy), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        reset = 1'b1;
        pos = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("mid_no_done", 32'(done), 32'h0);
        end

        // Randomized commands
        for (int i = 0; i < 25; i++) begin
            n   = $urandom_range(0, 12);
            per = $urandom_range(0, 4);
            ab  = 0;
            if (n > 0 && $urandom_range(0, 3) == 0)
                ab = $urandom_range(1, n * ((per == 0) ? 1 : per));
            run_cmd(1'($urandom), n, per, ab, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
